// File: rtl/div32_seq.sv
// rtl/div32_seq.sv - sequential signed non-restoring divider, one iteration per clock
module div32_seq #(
   parameter int WIDTH = 32
) (
   input  logic               clock,
   input  logic               clear,
   input  logic               start,
   input  logic [WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               busy,
   output logic               done,
   output logic               div_zero,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic [2*WIDTH-1:0] P
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

   state_t           state_q;
   logic [WIDTH:0]   a_q;        // partial remainder, sign in the top bit
   logic [WIDTH-1:0] q_q;        // dividend magnitude shifting out, quotient bits shifting in
   logic [WIDTH-1:0] m_q;        // divisor magnitude
   logic [WIDTH-1:0] dvd_q;      // dividend as presented, returned on divide by zero
   logic             sign_q_q;
   logic             sign_r_q;
   logic             dz_q;
   logic [CW-1:0]    count_q;
   logic             busy_q;
   logic             done_q;
   logic             div_zero_q;
   logic [WIDTH-1:0] quot_q;
   logic [WIDTH-1:0] rem_q;

   logic [WIDTH:0]   a_sh;
   logic [WIDTH:0]   a_d;
   logic [WIDTH-1:0] q_d;
   logic [WIDTH:0]   a_fix;
   logic [WIDTH-1:0] quot_fix;
   logic [WIDTH-1:0] rem_fix;
   logic [WIDTH-1:0] abs_dvd;
   logic [WIDTH-1:0] abs_dvs;

   // Operand magnitudes; -(2^31) maps onto itself, which is the correct unsigned magnitude.
   always_comb begin
      abs_dvd = dividend[WIDTH-1] ? -dividend : dividend;
      abs_dvs = divisor[WIDTH-1]  ? -divisor  : divisor;
   end

   // One non-restoring step: add or subtract the divisor based on the pre-shift sign of A.
   always_comb begin
      a_sh = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
      if (!a_q[WIDTH]) begin
         a_d = a_sh - {1'b0, m_q};
      end else begin
         a_d = a_sh + {1'b0, m_q};
      end
      q_d = {q_q[WIDTH-2:0], ~a_d[WIDTH]};
   end

   // Final correction of a negative partial remainder and sign restoration of both results.
   always_comb begin
      a_fix    = a_q[WIDTH] ? (a_q + {1'b0, m_q}) : a_q;
      quot_fix = sign_q_q ? -q_q : q_q;
      rem_fix  = sign_r_q ? -a_fix[WIDTH-1:0] : a_fix[WIDTH-1:0];
   end

   // Control FSM and all datapath registers; clear discards any in-flight operation.
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q    <= S_IDLE;
         a_q        <= '0;
         q_q        <= '0;
         m_q        <= '0;
         dvd_q      <= '0;
         sign_q_q   <= 1'b0;
         sign_r_q   <= 1'b0;
         dz_q       <= 1'b0;
         count_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         quot_q     <= '0;
         rem_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  q_q      <= abs_dvd;
                  m_q      <= abs_dvs;
                  dvd_q    <= dividend;
                  a_q      <= '0;
                  count_q  <= '0;
                  sign_q_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  sign_r_q <= dividend[WIDTH-1];
                  dz_q     <= (divisor == '0);
                  busy_q   <= 1'b1;
                  state_q  <= S_ITER;
               end else begin
                  state_q  <= S_IDLE;
               end
            end
            S_ITER: begin
               a_q     <= a_d;
               q_q     <= q_d;
               count_q <= count_q + CW'(1);
               if (count_q == CW'(WIDTH - 1)) begin
                  state_q <= S_FIX;
               end
            end
            S_FIX: begin
               a_q        <= a_fix;
               div_zero_q <= dz_q;
               if (dz_q) begin
                  quot_q <= '1;
                  rem_q  <= dvd_q;
               end else begin
                  quot_q <= quot_fix;
                  rem_q  <= rem_fix;
               end
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign div_zero  = div_zero_q;
   assign quotient  = quot_q;
   assign remainder = rem_q;
   assign P         = {rem_q, quot_q};

endmodule

// File: tb/tb_div32_seq.sv
// tb/tb_div32_seq.sv - self-checking bench for div32_seq
module tb_div32_seq;

   logic        clock;
   logic        clear;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic [63:0] P;

   div32_seq #(.WIDTH(32)) dut (
      .clock     (clock),
      .clear     (clear),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero),
      .quotient  (quotient),
      .remainder (remainder),
      .P         (P)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        dz;
   } vec_t;

   vec_t        vecs [10];
   int          checks = 0;
   int          passes = 0;
   logic [31:0] exp_prev_q = 32'h0;
   logic [31:0] exp_prev_r = 32'h0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s actual=%h expected=%h", name, act, exp);
   endtask

   // Drive a request so that the next rising edge accepts it.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
   endtask

   // Let the accepting edge happen, then wait for done; lat counts cycles from the accepting edge.
   task automatic wait_done(input int pulse_cyc, input bit hold, output int lat);
      @(posedge clock);
      @(negedge clock);
      lat = 1;
      if (!hold) start = 1'b0;
      dividend = $urandom;
      divisor  = $urandom;
      chk("busy_after_accept", {63'h0, busy}, 64'h1);
      while (!done && lat < 60) begin
         if (lat == pulse_cyc) begin
            start    = 1'b1;
            dividend = 32'd9;
            divisor  = 32'd2;
         end else if (!hold) begin
            start = 1'b0;
         end
         if (lat == 20) begin
            chk("hold_q_during_iter", {32'h0, quotient}, {32'h0, exp_prev_q});
            chk("hold_r_during_iter", {32'h0, remainder}, {32'h0, exp_prev_r});
         end
         @(negedge clock);
         lat++;
         if (busy && done) chk("busy_and_done", 64'h1, 64'h0);
      end
      if (!done) chk("done_timeout", 64'h0, 64'h1);
      else chk("busy_low_at_done", {63'h0, busy}, 64'h0);
   endtask

   task automatic check_result(input string tag, input logic [31:0] q, input logic [31:0] r,
                               input logic dz, input int lat);
      chk({tag, "_quotient"}, {32'h0, quotient}, {32'h0, q});
      chk({tag, "_remainder"}, {32'h0, remainder}, {32'h0, r});
      chk({tag, "_P"}, P, {r, q});
      chk({tag, "_div_zero"}, {63'h0, div_zero}, {63'h0, dz});
      chk({tag, "_latency"}, 64'(lat), 64'd34);
      exp_prev_q = q;
      exp_prev_r = r;
   endtask

   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r, output logic dz);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      sa = a;
      sb = b;
      dz = 1'b0;
      if (b == 32'h0) begin
         q  = 32'hFFFF_FFFF;
         r  = a;
         dz = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'h0;
      end else begin
         q = sa / sb;
         r = sa % sb;
      end
   endfunction

   initial begin
      int          lat;
      logic [31:0] rq;
      logic [31:0] rr;
      logic        rdz;
      logic [31:0] ra;
      logic [31:0] rb;
      bit          saw_done;

      vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
      vecs[1] = '{32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};
      vecs[2] = '{32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0};
      vecs[3] = '{32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0};
      vecs[4] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
      vecs[5] = '{32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0};
      vecs[6] = '{32'd5,          32'h8000_0000,  32'd0,          32'd5,          1'b0};
      vecs[7] = '{32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
      vecs[8] = '{32'd9,          32'd3,          32'd3,          32'd0,          1'b0};
      vecs[9] = '{32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};

      clear    = 1'b1;
      start    = 1'b0;
      dividend = 32'h0;
      divisor  = 32'h0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_busy", {63'h0, busy}, 64'h0);
      chk("rst_done", {63'h0, done}, 64'h0);
      chk("rst_div_zero", {63'h0, div_zero}, 64'h0);
      chk("rst_P", P, 64'h0);
      clear = 1'b0;

      // Directed table
      for (int i = 0; i < 10; i++) begin
         start_op(vecs[i].a, vecs[i].b);
         wait_done(-1, 1'b0, lat);
         check_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].dz, lat);
         @(negedge clock);
         chk($sformatf("vec%0d_done_one_cycle", i), {63'h0, done}, 64'h0);
      end

      // Start pulse while busy is ignored
      start_op(32'd50, 32'd5);
      wait_done(10, 1'b0, lat);
      check_result("ignored_start", 32'd10, 32'd0, 1'b0, lat);
      @(negedge clock);
      chk("ignored_start_no_second_op", {63'h0, busy}, 64'h0);

      // Start held high through DONE: back-to-back operations
      start_op(32'd50, 32'd5);
      wait_done(-1, 1'b1, lat);
      check_result("held_first", 32'd10, 32'd0, 1'b0, lat);
      dividend = 32'd1000;
      divisor  = 32'hFFFF_FFFD;
      wait_done(-1, 1'b0, lat);
      check_result("held_second", 32'hFFFF_FEB3, 32'd1, 1'b0, lat);
      @(negedge clock);

      // Clear mid-iteration, together with a start on the same edge
      start_op(32'd100, 32'd7);
      @(posedge clock);
      repeat (20) @(negedge clock);
      clear    = 1'b1;
      start    = 1'b1;
      dividend = 32'd3;
      divisor  = 32'd1;
      @(negedge clock);
      chk("clr_busy", {63'h0, busy}, 64'h0);
      chk("clr_done", {63'h0, done}, 64'h0);
      chk("clr_div_zero", {63'h0, div_zero}, 64'h0);
      chk("clr_P", P, 64'h0);
      clear = 1'b0;
      start = 1'b0;
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (done || busy) saw_done = 1'b1;
      end
      chk("clr_no_activity", {63'h0, saw_done}, 64'h0);
      exp_prev_q = 32'h0;
      exp_prev_r = 32'h0;
      start_op(32'd7, 32'd2);
      wait_done(-1, 1'b0, lat);
      check_result("after_clear", 32'd3, 32'd1, 1'b0, lat);

      // Random signed pairs against the reference model
      for (int i = 0; i < 150; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 4 == 0) rb = $urandom_range(0, 40) - 20;
         ref_div(ra, rb, rq, rr, rdz);
         start_op(ra, rb);
         wait_done(-1, 1'b0, lat);
         check_result($sformatf("rnd%0d", i), rq, rr, rdz, lat);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
